// File: rtl/pipeline_ctrl_if.sv
// Hazard inputs and stall/flush controls between the pipeline and its controller.
interface pipeline_ctrl_if;
   logic [4:0]  id_rj_index;
   logic [4:0]  id_rk_index;
   logic        id_rj_read;
   logic        id_rk_read;
   logic [4:0]  ex_rd_index;
   logic [4:0]  m1_rd_index;
   logic        ex_is_load;
   logic        m1_is_load;
   logic        ex_branch_taken;
   logic        ex_div_busy;
   logic        icache_busy;
   logic        dcache_busy;
   logic        wb_exception;
   logic        pc_stall;
   logic [4:0]  stall;
   logic [4:0]  clear;
   logic        excp_flush;
   logic        drain_timeout;
   logic [31:0] stall_cnt;

   modport master (
      output id_rj_index, id_rk_index, id_rj_read, id_rk_read,
      output ex_rd_index, m1_rd_index, ex_is_load, m1_is_load,
      output ex_branch_taken, ex_div_busy, icache_busy,
      output dcache_busy, wb_exception,
      input  pc_stall, stall, clear, excp_flush, drain_timeout,
      input  stall_cnt
   );

   modport slave (
      input  id_rj_index, id_rk_index, id_rj_read, id_rk_read,
      input  ex_rd_index, m1_rd_index, ex_is_load, m1_is_load,
      input  ex_branch_taken, ex_div_busy, icache_busy,
      input  dcache_busy, wb_exception,
      output pc_stall, stall, clear, excp_flush, drain_timeout,
      output stall_cnt
   );
endinterface

// File: rtl/pipeline_ctrl.sv
// Pipeline hazard/stall/flush controller with exception drain state.
// Define PIPE_STALL_CNT_EN to build the stalled-cycle counter.
module pipeline_ctrl #(
   parameter int unsigned DRAIN_LIMIT = 255
) (
   input logic             clk,
   input logic             rst,
   pipeline_ctrl_if.slave  bus
);
   localparam int CW = $clog2(DRAIN_LIMIT + 1);

   typedef enum logic {NORMAL, DRAIN} state_t;

   state_t        state, state_nxt;
   logic [CW-1:0] dcnt, dcnt_nxt;
   logic          pc_stall;
   logic [4:0]    stall;
   logic [4:0]    clear;
   logic          excp_flush;
   logic          drain_timeout;
   logic          ex_hit;
   logic          m1_hit;
   logic          load_use;
   logic          limit_hit;

   always_comb begin
      ex_hit = bus.ex_is_load && bus.ex_rd_index != 5'd0 &&
               ((bus.id_rj_read && bus.id_rj_index == bus.ex_rd_index) ||
                (bus.id_rk_read && bus.id_rk_index == bus.ex_rd_index));
      m1_hit = bus.m1_is_load && bus.m1_rd_index != 5'd0 &&
               ((bus.id_rj_read && bus.id_rj_index == bus.m1_rd_index) ||
                (bus.id_rk_read && bus.id_rk_index == bus.m1_rd_index));
      load_use  = ex_hit || m1_hit;
      limit_hit = dcnt == CW'(DRAIN_LIMIT);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= NORMAL;
         dcnt  <= '0;
      end else begin
         state <= state_nxt;
         dcnt  <= dcnt_nxt;
      end
   end

   always_comb begin
      pc_stall      = 1'b0;
      stall         = 5'b00000;
      clear         = 5'b00000;
      excp_flush    = 1'b0;
      drain_timeout = 1'b0;
      state_nxt     = state;
      dcnt_nxt      = dcnt;
      if (rst) begin
         pc_stall = 1'b1;
         clear    = 5'b11111;
      end else begin
         unique case (state)
            NORMAL: begin
               priority case (1'b1)
                  bus.wb_exception && !bus.dcache_busy: begin
                     clear      = 5'b11111;
                     excp_flush = 1'b1;
                  end
                  bus.wb_exception: begin
                     pc_stall  = 1'b1;
                     stall     = 5'b01111;
                     clear     = 5'b10000;
                     state_nxt = DRAIN;
                     dcnt_nxt  = '0;
                  end
                  bus.dcache_busy: begin
                     pc_stall = 1'b1;
                     stall    = 5'b01111;
                     clear    = 5'b10000;
                  end
                  bus.ex_div_busy: begin
                     pc_stall = 1'b1;
                     stall    = 5'b00011;
                     clear    = 5'b00100;
                  end
                  bus.ex_branch_taken: begin
                     clear = 5'b00011;
                  end
                  load_use: begin
                     pc_stall = 1'b1;
                     stall    = 5'b00001;
                     clear    = 5'b00010;
                  end
                  bus.icache_busy: begin
                     pc_stall = 1'b1;
                     clear    = 5'b00001;
                  end
                  default: ;
               endcase
            end
            DRAIN: begin
               // the limit forces the flush even if memory never answers
               if (limit_hit || !bus.dcache_busy) begin
                  clear         = 5'b11111;
                  excp_flush    = 1'b1;
                  drain_timeout = limit_hit;
                  state_nxt     = NORMAL;
               end else begin
                  pc_stall = 1'b1;
                  stall    = 5'b01111;
                  clear    = 5'b10000;
                  dcnt_nxt = dcnt + CW'(1);
               end
            end
            default: state_nxt = NORMAL;
         endcase
      end
   end

`ifdef PIPE_STALL_CNT_EN
   logic [31:0] scnt;

   always_ff @(posedge clk) begin
      if (rst)
         scnt <= '0;
      else if (pc_stall)
         scnt <= scnt + 32'd1;
   end

   assign bus.stall_cnt = scnt;
`else
   assign bus.stall_cnt = 32'd0;
`endif

   assign bus.pc_stall      = pc_stall;
   assign bus.stall         = stall;
   assign bus.clear         = clear;
   assign bus.excp_flush    = excp_flush;
   assign bus.drain_timeout = drain_timeout;
endmodule

// File: doc/pipeline_ctrl.md
PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

Interface
REQ-001 SHALL have parameter DRAIN_LIMIT, default 255, maximum number of DRAIN cycles before a forced flush.
REQ-002 SHALL have ports: clk  in  1  rising-edge clock.
REQ-003 SHALL have ports: rst  in  1  synchronous, active-high reset.
REQ-004 SHALL have ports: id_rj_index, id_rk_index  in  5 each  source register indices in ID.
REQ-005 SHALL have ports: id_rj_read, id_rk_read  in  1 each  ID instruction actually reads rj/rk.
REQ-006 SHALL have ports: ex_rd_index, m1_rd_index  in  5 each  destinations in EX and M1.
REQ-007 SHALL have ports: ex_is_load, m1_is_load  in  1 each  EX/M1 instruction is a load.
REQ-008 SHALL have ports: ex_branch_taken  in  1  EX redirects fetch.
REQ-009 SHALL have ports: ex_div_busy  in  1  multi-cycle divider occupies EX.
REQ-010 SHALL have ports: icache_busy  in  1  fetch not ready.
REQ-011 SHALL have ports: dcache_busy  in  1  M2 memory access outstanding.
REQ-012 SHALL have ports: wb_exception  in  1  WB instruction raises exception/ertn.
REQ-013 SHALL have ports: pc_stall  out  1  PC holds.
REQ-014 SHALL have ports: stall  out  5  hold bit per pipeline register; bit0=ID, 1=EX, 2=M1, 3=M2, 4=WB.
REQ-015 SHALL have ports: clear  out  5  bubble bit per register, same bit map; drives each stage's clear input.
REQ-016 SHALL have ports: excp_flush  out  1  one-cycle pulse, PC loads exception target.
REQ-017 SHALL have ports: drain_timeout  out  1  one-cycle pulse on forced flush.
REQ-018 SHALL have ports: stall_cnt  out  32  stalled-cycle counter.

Function
REQ-019 SHALL implement FSM states NORMAL and DRAIN; outputs are combinational from state and inputs; state, drain counter and stall_cnt are registered.
REQ-020 SHALL, in NORMAL, apply the first matching rule in priority order REQ-021..REQ-026; otherwise all outputs are 0.
REQ-021 wb_exception & !dcache_busy: clear=5'b11111, stall=0, pc_stall=0, excp_flush=1; stay NORMAL.
REQ-022 wb_exception & dcache_busy: pc_stall=1, stall=5'b01111, clear=5'b10000; go DRAIN, drain counter=0.
REQ-023 dcache_busy: pc_stall=1, stall=5'b01111, clear=5'b10000.
REQ-024 ex_div_busy: pc_stall=1, stall=5'b00011, clear=5'b00100.
REQ-025 ex_branch_taken: pc_stall=0, clear=5'b00011, stall=0; load-use and icache_busy are ignored.
REQ-026 load-use, i.e. (ex_is_load & ex_rd_index!=0) or (m1_is_load & m1_rd_index!=0) matching an id_rX_index whose read bit is set: pc_stall=1, stall=5'b00001, clear=5'b00010.
REQ-027 SHALL, when no rule REQ-021..REQ-026 matches and icache_busy=1, drive pc_stall=1 and clear=5'b00001.
REQ-028 SHALL never assert stall[i] and clear[i] together.
REQ-029 SHALL, in DRAIN, drive pc_stall=1, stall=5'b01111, clear=5'b10000 and ignore all other inputs, including wb_exception.
REQ-030 SHALL, in DRAIN with dcache_busy=0, drive clear=5'b11111, stall=0, pc_stall=0 and excp_flush=1 that cycle, then return to NORMAL.
REQ-031 SHALL increment the drain counter by 1 in each DRAIN cycle in which dcache_busy=1.
REQ-032 SHALL, when the drain counter reaches DRAIN_LIMIT, apply REQ-030 regardless of dcache_busy and also pulse drain_timeout=1.

Reset
REQ-033 SHALL, while rst=1, drive clear=5'b11111, stall=0, pc_stall=1, excp_flush=0, drain_timeout=0.
REQ-034 SHALL, on a clock edge with rst=1, set state to NORMAL, the drain counter to 0 and stall_cnt to 0.
REQ-035 SHALL let rst asserted in DRAIN abandon the drain without asserting excp_flush.

Configuration
REQ-036 With PIPE_STALL_CNT_EN defined, stall_cnt SHALL increment by 1 every non-reset cycle with pc_stall=1, wrapping from 0xFFFFFFFF to 0.
REQ-037 Without PIPE_STALL_CNT_EN, stall_cnt SHALL be constant 0 and no counter flops SHALL exist.

Verification
REQ-038 Load r5 in EX, ID reads rj=r5 -> one cycle with pc_stall=1, stall=00001, clear=00010; the next cycle is clean.
REQ-039 Load r0 in EX, ID reads r0 -> no stall.
REQ-040 ex_div_busy for 8 cycles, plus icache_busy and branch asserted simultaneously -> 8 cycles of stall=00011, clear=00100.
REQ-041 wb_exception with dcache_busy held 3 cycles -> DRAIN for 3 cycles (clear=10000); excp_flush=1 with clear=11111 in the cycle dcache_busy falls; then NORMAL.
REQ-042 DRAIN_LIMIT=4, dcache_busy stuck at 1 -> forced flush with drain_timeout=1 after 4 DRAIN cycles.
REQ-043 rst pulsed mid-DRAIN -> state NORMAL, stall_cnt=0, no excp_flush; with PIPE_STALL_CNT_EN, 10 stall cycles -> stall_cnt=10.
